cascade_recombine_accumulator: RTL

Downstream consumer of the overflow-adjust split. Accepts a stream of MSP/LSP half-word pairs from the cascade chain and accumulates each half in its own widened register, so no single half can overflow. After DEPTH beats it recombines the two sums into one full-width result and presents it on a valid/ready output. It sits between the PE cascade tail and the result write-back buffer.

---
 rtl/cascade_recombine_accumulator.sv | 131 +++++++++++++
 1 files changed

// File: rtl/cascade_recombine_accumulator.sv
// cascade_recombine_accumulator
// Accumulates DEPTH beats of MSP/LSP half-words in two widened sums, then
// recombines them into one RESULT_WIDTH result behind a valid/ready output.
// Optional saturation on recombine is enabled by defining the macro
// CASCADE_RECOMBINE_SAT_EN; without it the result wraps and out_overflow is 0.
module cascade_recombine_accumulator #(
  parameter int ACCUM_WIDTH  = 32,
  parameter int DEPTH        = 8,
  parameter int RESULT_WIDTH = 40
) (
  input  logic                    clk,
  input  logic                    rst_n,
  input  logic                    in_valid,
  output logic                    in_ready,
  input  logic [ACCUM_WIDTH-1:0]  in_msp,
  input  logic [ACCUM_WIDTH-1:0]  in_lsp,
  output logic                    out_valid,
  input  logic                    out_ready,
  output logic [RESULT_WIDTH-1:0] out_data,
  output logic                    out_overflow
);

  localparam int SPLIT  = ACCUM_WIDTH / 2;
  localparam int CNT_W  = $clog2(DEPTH);
  localparam int SUM_W  = SPLIT + CNT_W;
  localparam int FULL_W = SUM_W + SPLIT + 1;
  // Recombine at a width that also covers RESULT_WIDTH, so both the wrap
  // slice and the overflow test are always in range.
  localparam int EXT_W  = FULL_W + RESULT_WIDTH;

  typedef enum logic [1:0] {
    ST_ACCUM   = 2'd0,
    ST_COMBINE = 2'd1,
    ST_OUTPUT  = 2'd2
  } state_t;

  state_t                  state_q, state_d;
  logic [CNT_W-1:0]        cnt_q, cnt_d;
  logic [SUM_W-1:0]        lsp_sum_q, lsp_sum_d;
  logic [SUM_W-1:0]        msp_sum_q, msp_sum_d;
  logic [RESULT_WIDTH-1:0] out_data_q, out_data_d;
  logic                    out_ovf_q, out_ovf_d;

  logic [EXT_W-1:0]        msp_ext;
  logic [EXT_W-1:0]        lsp_ext;
  logic [EXT_W-1:0]        full_ext;
  logic                    full_too_big;
  logic                    unused_bits;

  // Upper halves of the input buses carry nothing for this block.
  assign unused_bits = ^{in_msp[ACCUM_WIDTH-1:SPLIT], in_lsp[ACCUM_WIDTH-1:SPLIT], full_ext};

  assign msp_ext      = {{(EXT_W-SUM_W){1'b0}}, msp_sum_q} << SPLIT;
  assign lsp_ext      = {{(EXT_W-SUM_W){1'b0}}, lsp_sum_q};
  assign full_ext     = msp_ext + lsp_ext;
  assign full_too_big = |full_ext[EXT_W-1:RESULT_WIDTH];

  // Handshake flags depend only on state, never on in_valid/out_ready.
  assign in_ready     = (state_q == ST_ACCUM);
  assign out_valid    = (state_q == ST_OUTPUT);
  assign out_data     = out_data_q;
  assign out_overflow = out_ovf_q;

  // Next-state, accumulation and recombine logic.
  always_comb begin
    state_d    = state_q;
    cnt_d      = cnt_q;
    lsp_sum_d  = lsp_sum_q;
    msp_sum_d  = msp_sum_q;
    out_data_d = out_data_q;
    out_ovf_d  = out_ovf_q;
    unique case (state_q)
      ST_ACCUM: begin
        if (in_valid) begin
          lsp_sum_d = lsp_sum_q + {{CNT_W{1'b0}}, in_lsp[SPLIT-1:0]};
          msp_sum_d = msp_sum_q + {{CNT_W{1'b0}}, in_msp[SPLIT-1:0]};
          cnt_d     = cnt_q + CNT_W'(1);
          if (cnt_q == CNT_W'(DEPTH - 1)) begin
            state_d = ST_COMBINE;
          end
        end
      end
      ST_COMBINE: begin
`ifdef CASCADE_RECOMBINE_SAT_EN
        if (full_too_big) begin
          out_data_d = '1;
          out_ovf_d  = 1'b1;
        end else begin
          out_data_d = full_ext[RESULT_WIDTH-1:0];
          out_ovf_d  = 1'b0;
        end
`else
        out_data_d = full_ext[RESULT_WIDTH-1:0];
        out_ovf_d  = 1'b0;
`endif
        lsp_sum_d = '0;
        msp_sum_d = '0;
        state_d   = ST_OUTPUT;
      end
      ST_OUTPUT: begin
        if (out_ready) begin
          out_ovf_d = 1'b0;
          state_d   = ST_ACCUM;
        end
      end
      default: begin
        state_d = ST_ACCUM;
      end
    endcase
  end

  // State and datapath registers with synchronous active-low reset.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q    <= ST_ACCUM;
      cnt_q      <= '0;
      lsp_sum_q  <= '0;
      msp_sum_q  <= '0;
      out_data_q <= '0;
      out_ovf_q  <= 1'b0;
    end else begin
      state_q    <= state_d;
      cnt_q      <= cnt_d;
      lsp_sum_q  <= lsp_sum_d;
      msp_sum_q  <= msp_sum_d;
      out_data_q <= out_data_d;
      out_ovf_q  <= out_ovf_d;
    end
  end

endmodule
